// File: rtl/frame_writer.sv
// Double-buffered RGB frame store for an LED matrix: pixel writes land in the back buffer, scans read the front buffer.
// Latency: writes commit at the accepting edge; scan data appears one cycle after SCAN_VALID.
// Backpressure: WR_READY is low while clearing, swapping, or while a swap is pending; scan reads are never stalled.
module frame_writer #(
  parameter int rows    = 8,
  parameter int columns = 12
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WR_VALID,
  output logic            WR_READY,
  input  logic [3:0]      WR_X,
  input  logic [2:0]      WR_Y,
  input  logic [2:0]      WR_COLOR,
  input  logic            WR_CLEAR,
  output logic            WR_ERR,
  input  logic            SWAP,
  input  logic            SCAN_VALID,
  input  logic [3:0]      SCAN_COL,
  output logic [rows-1:0] ROW_R,
  output logic [rows-1:0] ROW_G,
  output logic [rows-1:0] ROW_B,
  output logic            DATA_VALID,
  output logic            BUSY
);

  localparam logic [4:0] NCOL     = 5'(columns);
  localparam logic [3:0] NROW     = 4'(rows);
  localparam logic [3:0] COL_LAST = 4'(columns - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

  state_t         state, state_nxt;
  logic           ptr;        // selects the front buffer; the back buffer is ~ptr
  logic           back;
  logic           pending;
  logic [3:0]     clr_col;
  logic           wr_acc;
  logic           wr_in_range;
  logic           scan_last;
  logic           swap_fire;

  // one column vector per colour plane, indexed [buffer][column]
  logic [rows-1:0] mem_r [2][columns];
  logic [rows-1:0] mem_g [2][columns];
  logic [rows-1:0] mem_b [2][columns];

  assign back        = ~ptr;
  assign wr_acc      = WR_VALID & WR_READY;
  assign wr_in_range = ({1'b0, WR_X} < NCOL) && ({1'b0, WR_Y} < NROW);
  assign scan_last   = SCAN_VALID && (SCAN_COL == COL_LAST);
  // the pointer only flips on the last column of a scan so a frame is never torn
  assign swap_fire   = (state == SWAP_WAIT) && scan_last;

  // next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    WR_READY  = 1'b0;
    BUSY      = 1'b0;
    case (state)
      IDLE: begin
        WR_READY = ~pending;
        if (wr_acc && WR_CLEAR) state_nxt = CLEAR;
        else if (pending)       state_nxt = SWAP_WAIT;
      end
      CLEAR: begin
        BUSY = 1'b1;
        if (clr_col == COL_LAST) state_nxt = IDLE;
      end
      SWAP_WAIT: begin
        BUSY = 1'b1;
        if (scan_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register, buffer pointer, swap request latch and clear column counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      pending <= 1'b0;
      clr_col <= '0;
    end else begin
      state   <= state_nxt;
      if (swap_fire) ptr <= ~ptr;
      pending <= swap_fire ? 1'b0 : (pending | SWAP);
      clr_col <= (state == CLEAR) ? clr_col + 4'd1 : 4'd0;
    end
  end

  // out-of-range write indication, one cycle after the accepting edge
  always_ff @(posedge CLK) begin
    if (RST) WR_ERR <= 1'b0;
    else     WR_ERR <= wr_acc & ~WR_CLEAR & ~wr_in_range;
  end

  // back-buffer updates: column-per-cycle clear, or a single pixel write
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < columns; j++) begin
          mem_r[i][j] <= '0;
          mem_g[i][j] <= '0;
          mem_b[i][j] <= '0;
        end
      end
    end else if (state == CLEAR) begin
      mem_r[back][clr_col] <= '0;
      mem_g[back][clr_col] <= '0;
      mem_b[back][clr_col] <= '0;
    end else if (wr_acc && !WR_CLEAR && wr_in_range) begin
      mem_r[back][WR_X][WR_Y] <= WR_COLOR[2];
      mem_g[back][WR_X][WR_Y] <= WR_COLOR[1];
      mem_b[back][WR_X][WR_Y] <= WR_COLOR[0];
    end
  end

  // front-buffer column read; the old pointer is used on the swap edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      DATA_VALID <= 1'b0;
      ROW_R      <= '0;
      ROW_G      <= '0;
      ROW_B      <= '0;
    end else begin
      DATA_VALID <= SCAN_VALID;
      if (SCAN_VALID) begin
        if ({1'b0, SCAN_COL} < NCOL) begin
          ROW_R <= mem_r[ptr][SCAN_COL];
          ROW_G <= mem_g[ptr][SCAN_COL];
          ROW_B <= mem_b[ptr][SCAN_COL];
        end else begin
          ROW_R <= '0;
          ROW_G <= '0;
          ROW_B <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: vector table for write/swap/scan basics, hand sequences for clear, swap timing and reset.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: WR_READY and BUSY are checked explicitly along the sequences.
module tb_frame_writer;

  logic       CLK = 1'b0;
  logic       RST, WR_VALID, WR_CLEAR, SWAP, SCAN_VALID;
  logic [3:0] WR_X, SCAN_COL;
  logic [2:0] WR_Y, WR_COLOR;
  logic       WR_READY, WR_ERR, DATA_VALID, BUSY;
  logic [7:0] ROW_R, ROW_G, ROW_B;

  int errors = 0;
  int checks = 0;

  frame_writer #(.rows(8), .columns(12)) dut (
    .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .WR_X(WR_X), .WR_Y(WR_Y), .WR_COLOR(WR_COLOR), .WR_CLEAR(WR_CLEAR),
    .WR_ERR(WR_ERR), .SWAP(SWAP), .SCAN_VALID(SCAN_VALID), .SCAN_COL(SCAN_COL),
    .ROW_R(ROW_R), .ROW_G(ROW_G), .ROW_B(ROW_B), .DATA_VALID(DATA_VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       wv, wc;
    logic [3:0] x;
    logic [2:0] y, c;
    logic       sw, sv;
    logic [3:0] sc;
    logic       e_rdy, e_err, e_dv, e_busy;
    logic [7:0] e_r, e_g, e_b;
  } vec_t;

  vec_t vt[12];

  function automatic vec_t mk(input logic wv, wc, input logic [3:0] x, input logic [2:0] y, c,
                              input logic sw, sv, input logic [3:0] sc,
                              input logic rdy, err, dv, busy, input logic [7:0] r, g, b);
    vec_t v;
    v.wv = wv; v.wc = wc; v.x = x; v.y = y; v.c = c; v.sw = sw; v.sv = sv; v.sc = sc;
    v.e_rdy = rdy; v.e_err = err; v.e_dv = dv; v.e_busy = busy; v.e_r = r; v.e_g = g; v.e_b = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    WR_VALID = 0; WR_CLEAR = 0; WR_X = 0; WR_Y = 0; WR_COLOR = 0;
    SWAP = 0; SCAN_VALID = 0; SCAN_COL = 0;
  endtask

  task automatic check_outs(input string n, input logic rdy, err, dv, busy, input logic [7:0] r, g, b);
    chk({n, "_rdy"}, WR_READY, rdy);
    chk({n, "_err"}, WR_ERR, err);
    chk({n, "_dv"}, DATA_VALID, dv);
    chk({n, "_busy"}, BUSY, busy);
    chk({n, "_r"}, ROW_R, r);
    chk({n, "_g"}, ROW_G, g);
    chk({n, "_b"}, ROW_B, b);
  endtask

  task automatic scan_chk(input int col, input logic [7:0] r, g, b);
    SCAN_VALID = 1; SCAN_COL = 4'(col);
    tick();
    SCAN_VALID = 0;
    chk($sformatf("scan%0d_dv", col), DATA_VALID, 1);
    chk($sformatf("scan%0d_r", col), ROW_R, r);
    chk($sformatf("scan%0d_g", col), ROW_G, g);
    chk($sformatf("scan%0d_b", col), ROW_B, b);
  endtask

  task automatic wr(input logic [3:0] x, input logic [2:0] y, c);
    chk("wr_ready_before", WR_READY, 1);
    WR_VALID = 1; WR_X = x; WR_Y = y; WR_COLOR = c;
    tick();
    WR_VALID = 0;
    chk("wr_no_err", WR_ERR, 0);
  endtask

  task automatic do_swap();
    int n;
    SWAP = 1;
    tick();
    SWAP = 0;
    n = 0;
    while (!BUSY && n < 20) begin
      tick();
      n++;
    end
    chk("swap_wait_entry", BUSY, 1);
    SCAN_VALID = 1; SCAN_COL = 4'd11;
    tick();
    SCAN_VALID = 0;
    chk("swap_done", BUSY, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    idle_in();
    RST = 1;
    tick();
    tick();
    check_outs("reset", 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    RST = 0;

    //          wv wc x   y  c       sw sv sc    rdy err dv busy r      g  b
    vt[0]  = mk(1, 0, 3,  5, 3'b100, 0, 0, 0,    1,  0,  0, 0,   8'h00, 0, 0);
    vt[1]  = mk(0, 0, 0,  0, 0,      1, 0, 0,    0,  0,  0, 0,   8'h00, 0, 0);
    vt[2]  = mk(0, 0, 0,  0, 0,      0, 0, 0,    0,  0,  0, 1,   8'h00, 0, 0);
    vt[3]  = mk(0, 0, 0,  0, 0,      0, 1, 11,   1,  0,  1, 0,   8'h00, 0, 0);
    vt[4]  = mk(0, 0, 0,  0, 0,      0, 1, 3,    1,  0,  1, 0,   8'h20, 0, 0);
    vt[5]  = mk(0, 0, 0,  0, 0,      0, 0, 0,    1,  0,  0, 0,   8'h20, 0, 0);
    vt[6]  = mk(1, 0, 12, 0, 3'b111, 0, 0, 0,    1,  1,  0, 0,   8'h20, 0, 0);
    vt[7]  = mk(0, 0, 0,  0, 0,      0, 0, 0,    1,  0,  0, 0,   8'h20, 0, 0);
    vt[8]  = mk(1, 0, 15, 7, 3'b111, 0, 0, 0,    1,  1,  0, 0,   8'h20, 0, 0);
    vt[9]  = mk(0, 0, 0,  0, 0,      1, 0, 0,    0,  0,  0, 0,   8'h20, 0, 0);
    vt[10] = mk(0, 0, 0,  0, 0,      0, 0, 0,    0,  0,  0, 1,   8'h20, 0, 0);
    vt[11] = mk(0, 0, 0,  0, 0,      0, 1, 11,   1,  0,  1, 0,   8'h00, 0, 0);

    for (int i = 0; i < 12; i++) begin
      WR_VALID = vt[i].wv; WR_CLEAR = vt[i].wc; WR_X = vt[i].x; WR_Y = vt[i].y;
      WR_COLOR = vt[i].c; SWAP = vt[i].sw; SCAN_VALID = vt[i].sv; SCAN_COL = vt[i].sc;
      tick();
      check_outs($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_err, vt[i].e_dv, vt[i].e_busy,
                 vt[i].e_r, vt[i].e_g, vt[i].e_b);
    end
    idle_in();

    // out-of-range writes must not have landed anywhere in the new front buffer
    for (int c = 0; c < 12; c++) scan_chk(c, 8'h00, 8'h00, 8'h00);

    // populate the back buffer, present it, and probe including out-of-range columns
    wr(4'd0, 3'd0, 3'b010);
    wr(4'd11, 3'd7, 3'b001);
    do_swap();
    scan_chk(3, 8'h20, 8'h00, 8'h00);
    scan_chk(0, 8'h00, 8'h01, 8'h00);
    scan_chk(11, 8'h00, 8'h00, 8'h80);
    scan_chk(12, 8'h00, 8'h00, 8'h00);
    scan_chk(15, 8'h00, 8'h00, 8'h00);

    // new back buffer keeps old front contents across two swaps
    wr(4'd5, 3'd1, 3'b111);
    do_swap();
    scan_chk(5, 8'h02, 8'h02, 8'h02);
    do_swap();
    scan_chk(3, 8'h20, 8'h00, 8'h00);

    // clear of the back buffer with a SWAP arriving mid-clear
    chk("clr_ready_before", WR_READY, 1);
    WR_VALID = 1; WR_CLEAR = 1; WR_X = 4'd2; WR_COLOR = 3'b111;
    tick();
    idle_in();
    cnt = (BUSY && !WR_READY) ? 1 : 0;
    for (int k = 1; k <= 12; k++) begin
      SWAP = (k == 5);
      SCAN_VALID = (k >= 6);
      SCAN_COL = 4'd11;
      tick();
      if (k <= 11 && BUSY && !WR_READY) cnt++;
      if (k >= 6) begin
        chk($sformatf("clr_scan%0d_dv", k), DATA_VALID, 1);
        chk($sformatf("clr_scan%0d_b", k), ROW_B, 8'h80);
      end
    end
    chk("clr_busy_cycles", cnt, 12);
    chk("clr_end_busy", BUSY, 0);
    chk("clr_end_rdy_pending", WR_READY, 0);
    SWAP = 0; SCAN_VALID = 1; SCAN_COL = 4'd11;
    tick();
    chk("post_clr_swapwait_busy", BUSY, 1);
    chk("post_clr_swapwait_b", ROW_B, 8'h80);
    tick();
    SCAN_VALID = 0;
    chk("post_clr_swap_busy", BUSY, 0);
    chk("post_clr_swap_rdy", WR_READY, 1);
    chk("post_clr_swap_old_b", ROW_B, 8'h80);
    scan_chk(5, 8'h00, 8'h00, 8'h00);
    scan_chk(0, 8'h00, 8'h00, 8'h00);

    // pointer holds while scanning columns 0..10, flips only at column 11
    SWAP = 1;
    tick();
    SWAP = 0;
    chk("swp_pending_rdy", WR_READY, 0);
    tick();
    chk("swp_wait_busy", BUSY, 1);
    for (int c = 0; c <= 10; c++) begin
      scan_chk(c, 8'h00, 8'h00, 8'h00);
      chk($sformatf("swp_hold%0d_busy", c), BUSY, 1);
    end
    scan_chk(11, 8'h00, 8'h00, 8'h00);
    chk("swp_flip_busy", BUSY, 0);
    scan_chk(0, 8'h00, 8'h01, 8'h00);

    // reset during the fifth clear cycle
    WR_VALID = 1; WR_CLEAR = 1;
    tick();
    idle_in();
    for (int k = 1; k <= 4; k++) tick();
    chk("rstclr_busy_before", BUSY, 1);
    RST = 1;
    tick();
    RST = 0;
    check_outs("rst_mid_clear", 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    tick();
    chk("rst_stays_idle", BUSY, 0);
    for (int c = 0; c < 12; c++) scan_chk(c, 8'h00, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 SHALL have parameter rows, default 8, LED matrix row count.
REQ-002 SHALL have parameter columns, default 12, LED matrix column count.
REQ-003 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port WR_VALID  input  1  pixel write / clear request valid.
REQ-006 SHALL have port WR_READY  output  1  write channel accepts when high.
REQ-007 SHALL have port WR_X  input  4  target column index.
REQ-008 SHALL have port WR_Y  input  3  target row index.
REQ-009 SHALL have port WR_COLOR  input  3  {R,G,B} pixel bits.
REQ-010 SHALL have port WR_CLEAR  input  1  qualifies WR_VALID as a whole-back-buffer clear.
REQ-011 SHALL have port WR_ERR  output  1  one-cycle pulse: accepted write was out of range.
REQ-012 SHALL have port SWAP  input  1  one-cycle request to present the back buffer.
REQ-013 SHALL have port SCAN_VALID  input  1  screen driver requests one column.
REQ-014 SHALL have port SCAN_COL  input  4  requested column index.
REQ-015 SHALL have port ROW_R / ROW_G / ROW_B  output  rows each  front-buffer column data.
REQ-016 SHALL have port DATA_VALID  output  1  ROW_* valid for the request of the previous cycle.
REQ-017 SHALL have port BUSY  output  1  high in CLEAR or SWAP_WAIT.

Function
REQ-018 SHALL hold two frame buffers of columns x rows x 3 bits; one front (scan side), one back (write side), selected by a 1-bit pointer.
REQ-019 SHALL implement states IDLE, CLEAR, SWAP_WAIT.
REQ-020 SHALL assert WR_READY only in IDLE with no swap pending.
REQ-021 SHALL, on WR_VALID&WR_READY&!WR_CLEAR with WR_X<columns and WR_Y<rows, write WR_COLOR to back[WR_X][WR_Y] at that edge.
REQ-022 SHALL, on an accepted write with WR_X>=columns or WR_Y>=rows, leave buffers unchanged and pulse WR_ERR the following cycle.
REQ-023 SHALL, on WR_VALID&WR_READY&WR_CLEAR, enter CLEAR and zero one back-buffer column per cycle, 0..columns-1 (columns cycles), then return to IDLE; WR_X/WR_Y/WR_COLOR ignored.
REQ-024 SHALL latch SWAP into a pending flag in any state; repeated SWAP while pending has no further effect.
REQ-025 SHALL, in IDLE with swap pending, enter SWAP_WAIT; SWAP in CLEAR waits until CLEAR completes.
REQ-026 SHALL, in SWAP_WAIT, toggle the buffer pointer on the edge accepting SCAN_VALID with SCAN_COL==columns-1 (frame end, no tearing), clear pending, return to IDLE.
REQ-027 SHALL leave the new back buffer holding the previous front contents after a swap (no auto-clear).
REQ-028 SHALL, for SCAN_VALID at cycle N, drive ROW_R/G/B from front[SCAN_COL] and DATA_VALID=1 at cycle N+1; DATA_VALID=0 and ROW_* hold last value otherwise.
REQ-029 SHALL return all-zero ROW_* with DATA_VALID=1 for SCAN_COL>=columns.
REQ-030 SHALL serve scan reads every cycle independent of write state; the column read on the swap edge comes from the old front buffer.
REQ-031 SHALL, when a swap occurs and a write is accepted on the same edge, apply the write to the pre-swap back buffer.

Reset
REQ-032 SHALL, on RST high at an edge: both buffers zero, pointer 0, pending 0, state IDLE, WR_READY 1, WR_ERR 0, DATA_VALID 0, ROW_* 0, BUSY 0.
REQ-033 SHALL let RST override any in-progress CLEAR or SWAP_WAIT at the same edge.

Verification
REQ-034 SHALL cover: write (X=3,Y=5,COLOR=3'b100), SWAP, scan col 11 then col 3 -> next cycle ROW_R=8'b0010_0000, ROW_G=ROW_B=0, DATA_VALID=1.
REQ-035 SHALL cover: write X=12,Y=0 -> WR_ERR pulses 1 cycle, subsequent swap+scan of all columns returns all zeros.
REQ-036 SHALL cover: CLEAR accepted -> WR_READY=0, BUSY=1 for exactly 12 cycles; a SWAP mid-clear swaps only at the first SCAN_COL==11 after clear completes.
REQ-037 SHALL cover: SWAP then scan cols 0..10 -> pointer unchanged, scanned data from old front; scan col 11 -> next request returns new frame.
REQ-038 SHALL cover: RST asserted during CLEAR cycle 5 -> next cycle all outputs at reset values, scan of any column returns zeros.
